// File: rtl/poly_voice_engine.sv
// poly_voice_engine: time-multiplexed polyphonic DDS voice engine with ASR envelopes and a saturated mix
// Ports: i_clk/i_reset_n clock and async active-low reset; i_cmd_* note-on/off command with valid/ready
// handshake (o_cmd_ready); i_wave_sel global waveform; o_sample/o_sample_valid mixed output and strobe;
// o_active_voices one bit per non-idle voice.
module poly_voice_engine #(
  parameter int NUM_VOICES   = 8,
  parameter int PHASE_W      = 32,
  parameter int ENV_W        = 16,
  parameter int VEL_W        = 7,
  parameter int OUT_W        = 24,
  parameter int SAMPLE_DIV   = 1024,
  parameter int ATTACK_STEP  = 64,
  parameter int RELEASE_STEP = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic                          i_cmd_note_on,
  input  logic [$clog2(NUM_VOICES)-1:0] i_cmd_voice,
  input  logic [PHASE_W-1:0]            i_cmd_tuning,
  input  logic [VEL_W-1:0]              i_cmd_velocity,
  input  logic [1:0]                    i_wave_sel,
  output logic signed [OUT_W-1:0]       o_sample,
  output logic                          o_sample_valid,
  output logic [NUM_VOICES-1:0]         o_active_voices
);
  localparam int VW = $clog2(NUM_VOICES);
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int AW = 16 + VEL_W + VW;
  localparam int SW = (AW > OUT_W ? AW : OUT_W) + 1;
  localparam logic [TW-1:0] T_SCAN = TW'(NUM_VOICES);
  localparam logic [TW-1:0] T_OUT  = TW'(NUM_VOICES + 2);
  localparam logic [TW-1:0] T_RDY  = TW'(NUM_VOICES + 3);
  localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [ENV_W-1:0] ENV_MAX = '1;
  localparam logic [ENV_W-1:0] REL = ENV_W'(RELEASE_STEP);

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  logic [TW-1:0]           r_tick;
  logic [PHASE_W-1:0]      r_phase  [NUM_VOICES];
  logic [PHASE_W-1:0]      r_tuning [NUM_VOICES];
  logic [VEL_W-1:0]        r_vel    [NUM_VOICES];
  logic [ENV_W-1:0]        r_env    [NUM_VOICES];
  state_t                  r_state  [NUM_VOICES];
  logic [NUM_VOICES-1:0]   r_active;
  logic                    r_s1_valid, r_s2_valid;
  logic signed [15:0]      r_s1_wave, r_s2_a;
  logic [ENV_W-1:0]        r_s1_env;
  logic [VEL_W-1:0]        r_s1_vel, r_s2_vel;
  logic signed [AW-1:0]    r_acc;
  logic signed [OUT_W-1:0] r_sample;
  logic                    r_sample_valid;

  logic                    w_scan, w_cmd, w_off, w_att_full;
  logic [VW-1:0]           w_v;
  logic [15:0]             w_p;
  logic signed [15:0]      w_wave, w_a;
  logic [ENV_W:0]          w_att;
  logic [ENV_W-1:0]        w_nxt_env;
  state_t                  w_nxt_state;
  logic [PHASE_W-1:0]      w_nxt_phase;
  logic signed [ENV_W+16:0] w_prod;
  logic signed [VEL_W+16:0] w_b;
  logic signed [SW-1:0]    w_ext, w_max, w_min;
  logic signed [OUT_W-1:0] w_sat;
  logic [NUM_VOICES-1:0]   w_active;

  // Ticks 0..NUM_VOICES-1 visit one voice each; the scan writes back the voice it reads,
  // and commands are only accepted outside the scan window, so the two never collide.
  assign w_scan = r_tick < T_SCAN;
  assign w_v    = r_tick[VW-1:0];
  assign w_p    = r_phase[w_v][PHASE_W-1 -: 16];
  assign w_cmd  = i_cmd_valid && o_cmd_ready;
  assign w_off  = !i_cmd_note_on || i_cmd_velocity == '0;

  always_comb begin
    w_wave = r_state[w_v] == IDLE || i_wave_sel == 2'b11 ? 16'sd0 :
             i_wave_sel == 2'b00 ? {~w_p[15], w_p[14:0]} :
             i_wave_sel == 2'b01 ? (w_p[15] ? 16'sh8001 : 16'sh7fff) :
             w_p[15] ? 16'h7fff - {w_p[14:0], 1'b0} : {~w_p[14], w_p[13:0], 1'b0};
    w_att       = {1'b0, r_env[w_v]} + (ENV_W+1)'(ATTACK_STEP);
    w_att_full  = w_att >= {1'b0, ENV_MAX};
    w_nxt_phase = r_state[w_v] == IDLE ? r_phase[w_v] : r_phase[w_v] + r_tuning[w_v];
    w_nxt_env   = r_state[w_v] == ATTACK ? (w_att_full ? ENV_MAX : w_att[ENV_W-1:0]) :
                  r_state[w_v] == RELEASE ? (r_env[w_v] <= REL ? '0 : r_env[w_v] - REL) : r_env[w_v];
    w_nxt_state = r_state[w_v] == ATTACK && w_att_full ? SUSTAIN :
                  r_state[w_v] == RELEASE && r_env[w_v] <= REL ? IDLE : r_state[w_v];
    w_prod = r_s1_wave * $signed({1'b0, r_s1_env});
    w_a    = 16'(w_prod >>> ENV_W);
    w_b    = r_s2_a * $signed({1'b0, r_s2_vel});
    w_ext  = SW'(r_acc);
    w_max  = SW'({(OUT_W-1){1'b1}});
    w_min  = ~w_max;
    w_sat  = w_ext > w_max ? w_max[OUT_W-1:0] : w_ext < w_min ? w_min[OUT_W-1:0] : w_ext[OUT_W-1:0];
    w_active = '0;
    for (int i = 0; i < NUM_VOICES; i++) w_active[i] = r_state[i] != IDLE;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tick         <= '0;
      r_active       <= '0;
      r_s1_valid     <= 1'b0;
      r_s2_valid     <= 1'b0;
      r_s1_wave      <= '0;
      r_s2_a         <= '0;
      r_s1_env       <= '0;
      r_s1_vel       <= '0;
      r_s2_vel       <= '0;
      r_acc          <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_phase[i]  <= '0;
        r_tuning[i] <= '0;
        r_vel[i]    <= '0;
        r_env[i]    <= '0;
        r_state[i]  <= IDLE;
      end
    end else begin
      r_tick         <= r_tick == T_LAST ? '0 : r_tick + TW'(1);
      r_active       <= w_active;
      r_s1_valid     <= w_scan;
      r_s1_wave      <= w_wave;
      r_s1_env       <= r_env[w_v];
      r_s1_vel       <= r_vel[w_v];
      r_s2_valid     <= r_s1_valid;
      r_s2_a         <= w_a;
      r_s2_vel       <= r_s1_vel;
      r_acc          <= r_tick == T_OUT ? '0 : r_s2_valid ? r_acc + AW'(w_b) : r_acc;
      r_sample_valid <= r_tick == T_OUT;
      if (r_tick == T_OUT) r_sample <= w_sat;
      if (w_scan) begin
        r_phase[w_v] <= w_nxt_phase;
        r_env[w_v]   <= w_nxt_env;
        r_state[w_v] <= w_nxt_state;
      end
      if (w_cmd && w_off && (r_state[i_cmd_voice] == ATTACK || r_state[i_cmd_voice] == SUSTAIN))
        r_state[i_cmd_voice] <= RELEASE;
      // Retrigger keeps the current envelope so the restart does not click.
      if (w_cmd && !w_off) begin
        r_tuning[i_cmd_voice] <= i_cmd_tuning;
        r_vel[i_cmd_voice]    <= i_cmd_velocity;
        r_phase[i_cmd_voice]  <= '0;
        r_state[i_cmd_voice]  <= ATTACK;
      end
    end
  end

  assign o_cmd_ready     = r_tick >= T_RDY;
  assign o_sample        = r_sample;
  assign o_sample_valid  = r_sample_valid;
  assign o_active_voices = r_active;
endmodule

// File: tb/tb_poly_voice_engine.sv
// tb_poly_voice_engine: randomized and directed checks of poly_voice_engine against an integer voice model
module tb_poly_voice_engine;
  localparam int NV = 8;
  localparam int DIV = 12;
  localparam longint SMAX = 8388607;
  localparam longint SMIN = -8388608;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_note_on = 1'b0;
  logic [2:0]  cmd_voice = '0;
  logic [31:0] cmd_tuning = '0;
  logic [6:0]  cmd_vel = '0;
  logic [1:0]  wave_sel = '0;
  logic        ready, valid;
  logic signed [23:0] sample;
  logic [7:0]  active;

  always #5 clk = ~clk;

  poly_voice_engine #(.NUM_VOICES(NV), .SAMPLE_DIV(DIV)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(ready),
    .i_cmd_note_on(cmd_note_on), .i_cmd_voice(cmd_voice), .i_cmd_tuning(cmd_tuning),
    .i_cmd_velocity(cmd_vel), .i_wave_sel(wave_sel), .o_sample(sample),
    .o_sample_valid(valid), .o_active_voices(active)
  );

  int checks = 0, failures = 0;
  int m_state [NV];
  longint m_env [NV];
  longint m_vel [NV];
  logic [31:0] m_phase [NV], m_tun [NV];
  longint exp_sample, last_sample;
  logic [7:0] last_active;
  bit have_exp, accepted;
  int bt, acc_tick, cyc_cnt = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint wave_of(input logic [1:0] sel, input logic [15:0] p);
    longint x = longint'(p);
    case (sel)
      2'd0: return x - 32768;
      2'd1: return p[15] ? -32767 : 32767;
      2'd2: return p[15] ? 32767 - 2 * (x % 32768) : 2 * (x % 32768) - 32768;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_state[v] = 0; m_env[v] = 0; m_vel[v] = 0; m_phase[v] = '0; m_tun[v] = '0;
    end
    have_exp = 0;
    last_sample = -1;
  endtask

  // state: 0 idle, 1 attack, 2 sustain, 3 release
  task automatic model_scan();
    longint sum = 0, a;
    for (int v = 0; v < NV; v++) begin
      if (m_state[v] != 0) begin
        a = (wave_of(wave_sel, m_phase[v][31:16]) * m_env[v]) >>> 16;
        sum += a * m_vel[v];
        m_phase[v] += m_tun[v];
        if (m_state[v] == 1) begin
          m_env[v] = m_env[v] + 64 > 65535 ? 65535 : m_env[v] + 64;
          if (m_env[v] == 65535) m_state[v] = 2;
        end else if (m_state[v] == 3) begin
          m_env[v] = m_env[v] - 16 < 0 ? 0 : m_env[v] - 16;
          if (m_env[v] == 0) m_state[v] = 0;
        end
      end
    end
    exp_sample = sum > SMAX ? SMAX : sum < SMIN ? SMIN : sum;
  endtask

  function automatic logic [7:0] model_active();
    logic [7:0] r = '0;
    for (int v = 0; v < NV; v++) r[v] = m_state[v] != 0;
    return r;
  endfunction

  task automatic model_cmd();
    int v = int'(cmd_voice);
    if (cmd_note_on && cmd_vel != 0) begin
      m_tun[v] = cmd_tuning; m_vel[v] = longint'(cmd_vel); m_phase[v] = '0; m_state[v] = 1;
    end else if (m_state[v] == 1 || m_state[v] == 2) m_state[v] = 3;
  endtask

  task automatic cyc();
    @(negedge clk);
    cyc_cnt++;
    if (cyc_cnt > 95000) begin
      failures++;
      $display("FAIL cycle_budget got=%0d exp=95000", cyc_cnt);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "cycle budget exhausted");
    end
    if (rst_n) begin
      if (bt == 0) begin model_scan(); have_exp = 1; end
      chk("ready", longint'(ready), longint'(bt >= NV + 3));
      chk("valid", longint'(valid), longint'(have_exp && bt == NV + 3));
      if (valid) begin last_sample = longint'(sample); last_active = active; end
      if (have_exp && bt == NV + 3) begin
        chk("sample", longint'(sample), exp_sample);
        chk("active", longint'(active), longint'(model_active()));
      end
      if (cmd_valid && ready) begin model_cmd(); accepted = 1; acc_tick = bt; end
    end
    @(posedge clk);
    #1;
    if (rst_n) bt = (bt + 1) % DIV;
  endtask

  task automatic send(input bit on, input int v, input logic [31:0] tun, input logic [6:0] vel);
    cmd_note_on = on; cmd_voice = 3'(v); cmd_tuning = tun; cmd_vel = vel;
    cmd_valid = 1; accepted = 0;
    for (int i = 0; i < 3 * DIV && !accepted; i++) cyc();
    cmd_valid = 0;
    chk("accept_timeout", longint'(accepted), 1);
  endtask

  task automatic wait_samples(input int n);
    for (int i = 0; i < n * DIV; i++) cyc();
  endtask

  task automatic wait_tick(input int t);
    for (int i = 0; i < DIV && bt != t; i++) cyc();
  endtask

  task automatic set_wave(input logic [1:0] w);
    wait_tick(NV);
    wave_sel = w;
  endtask

  function automatic bit all_state(input int s);
    for (int v = 0; v < NV; v++) if (m_state[v] != s) return 0;
    return 1;
  endfunction

  initial begin
    bit ok;
    model_reset();
    bt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sample", longint'(sample), 0);
    chk("rst_valid", longint'(valid), 0);
    chk("rst_active", longint'(active), 0);
    chk("rst_ready", longint'(ready), 0);
    rst_n = 1;

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) set_wave(2'($urandom_range(0, 3)));
      send($urandom_range(0, 3) != 0, $urandom_range(0, NV - 1), $urandom,
           $urandom_range(0, 7) == 0 ? 7'd0 : 7'($urandom_range(1, 127)));
      repeat ($urandom_range(0, 20)) cyc();
    end

    for (int v = 1; v <= 3; v++) send(1, v, $urandom, 7'd100);
    wait_samples(2);
    wait_tick(3);
    rst_n = 0;
    #1;
    chk("midrst_sample", longint'(sample), 0);
    chk("midrst_valid", longint'(valid), 0);
    chk("midrst_active", longint'(active), 0);
    chk("midrst_ready", longint'(ready), 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    wave_sel = 2'b00;
    rst_n = 1;
    bt = 0;

    send(1, 5, 32'd20_000_000, 7'd127);
    chk("hs_tick", acc_tick, NV + 3);
    chk("first_sample", last_sample, 0);
    wait_samples(1024);
    chk("single_active", longint'(active), 32);

    set_wave(2'b01);
    send(1, 5, 32'd0, 7'd127);
    wait_samples(2);
    chk("one_voice", last_sample, 4161282);

    send(1, 0, 32'd0, 7'd127);
    for (int v = 1; v < NV; v++) if (v != 5) send(1, v, 32'd0, 7'd127);
    for (int i = 0; i < 600 * DIV && m_env[0] < 30016; i++) cyc();
    chk("wait_attack", longint'(m_env[0] >= 30016), 1);
    send(0, 0, 32'd0, 7'd0);
    for (int i = 0; i < 3 * DIV && m_env[0] != 30000; i++) cyc();
    chk("wait_release", longint'(m_env[0] == 30000), 1);
    send(1, 0, 32'd0, 7'd127);
    for (int i = 0; i < 1200 * DIV && !all_state(2); i++) cyc();
    chk("wait_sustain", longint'(all_state(2)), 1);
    wait_samples(2);
    chk("all_sat", last_sample, SMAX);

    for (int v = 0; v < NV; v++) send(v < 4, v, 32'd0, 7'd0);
    for (int i = 0; i < 4200 * DIV && !all_state(0); i++) cyc();
    ok = all_state(0);
    chk("wait_idle", longint'(ok), 1);
    wait_samples(3);
    chk("rel_active", longint'(last_active), 0);
    chk("rel_sample", last_sample, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
